sevseg_scan_ctrl: RTL

Parametrised multiplexed 7-segment display driver. Scans NUM_DIGITS BCD digits with per-digit decimal points, optional leading-zero blanking and configurable polarity. Inserts an inter-digit blanking gap to suppress ghosting. Latches display data at frame boundaries so a frame never shows half-old, half-new digits. Sits between the WPM/BCD datapath and the board's SEG/DP/AN pins.

---
 rtl/sevseg_scan_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed 7-segment scan driver with frame-latched data and blanking gap.
// Optional per-digit blinking is enabled by defining SEVSEG_BLINK_EN.
module sevseg_scan_ctrl #(
  parameter int NUM_DIGITS     = 5,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
`ifdef SEVSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   bcd_in,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
`ifdef SEVSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
  input  logic                      lz_blank_en,
  output logic [6:0]                SEG,
  output logic                      DP,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic                      frame_start
);

  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    first;
  logic [4*NUM_DIGITS-1:0] sh_bcd;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_lz;

  logic                    wrap_slot;
  logic                    last_idx;
  logic                    boundary;
  logic                    active;
  logic                    lead;
  logic                    lz_hit;
  logic                    blink_off;
  logic [3:0]              digit;
  logic [6:0]              seg_lt;
  logic                    dp_on;
  logic [NUM_DIGITS-1:0]   an_on;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  endfunction

  assign wrap_slot = cnt == CW'(REFRESH_DIV - 1);
  assign last_idx  = idx == IW'(NUM_DIGITS - 1);
  // The first clock out of reset acts as a frame boundary with cnt held at 0.
  assign boundary  = first | (wrap_slot & last_idx);
  assign active    = cnt >= CW'(BLANK_CYCLES);
  assign digit     = sh_bcd[{idx, 2'b00} +: 4];

  always_comb begin
    lead = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) &&
          (sh_bcd[4*j +: 4] != 4'd0 || sh_dp[j]))
        lead = 1'b0;
    end
    lz_hit = sh_lz & lead & (idx != '0);
  end

  always_comb begin
    seg_lt = (lz_hit | blink_off) ? 7'h7f : dec(digit);
    dp_on  = sh_dp[idx] & ~blink_off;
    an_on  = '0;
    an_on[idx] = active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      first       <= 1'b1;
      sh_bcd      <= '0;
      sh_dp       <= '0;
      sh_lz       <= 1'b0;
      frame_start <= 1'b0;
      AN          <= AN_OFF;
      SEG         <= SEG_OFF;
      DP          <= DP_OFF;
    end else begin
      first       <= 1'b0;
      frame_start <= boundary;
      if (boundary) begin
        sh_bcd <= bcd_in;
        sh_dp  <= dp_mask;
        sh_lz  <= lz_blank_en;
      end
      if (!first) begin
        if (wrap_slot) begin
          cnt <= '0;
          idx <= last_idx ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (active) begin
        AN  <= AN_ACTIVE_LOW ? ~an_on : an_on;
        SEG <= SEG_ACTIVE_LOW ? seg_lt : ~seg_lt;
        DP  <= SEG_ACTIVE_LOW ? ~dp_on : dp_on;
      end else begin
        AN  <= AN_OFF;
        SEG <= SEG_OFF;
        DP  <= DP_OFF;
      end
    end
  end

`ifdef SEVSEG_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0]         fcnt;
  logic                  phase;
  logic [NUM_DIGITS-1:0] sh_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt     <= '0;
      phase    <= 1'b0;
      sh_blink <= '0;
    end else if (boundary) begin
      sh_blink <= blink_mask;
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign blink_off = phase & sh_blink[idx];
`else
  assign blink_off = 1'b0;
`endif

endmodule
